// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - baud_div(): maps the 3-bit baud_rate_select code to a clock-per-bit
//     divisor, so both ends of a link use one encoding.
//   - DIV_* constants: the eight divisors in clocks per bit.
//   - rx_state_t: receiver FSM state encoding (3 bits).
package uart_pkg;

  localparam int unsigned CNT_W = 11;

  localparam logic [CNT_W-1:0] DIV_000 = 11'd1042;
  localparam logic [CNT_W-1:0] DIV_001 = 11'd695;
  localparam logic [CNT_W-1:0] DIV_010 = 11'd521;
  localparam logic [CNT_W-1:0] DIV_011 = 11'd261;
  localparam logic [CNT_W-1:0] DIV_100 = 11'd174;
  localparam logic [CNT_W-1:0] DIV_101 = 11'd87;
  localparam logic [CNT_W-1:0] DIV_110 = 11'd79;
  localparam logic [CNT_W-1:0] DIV_111 = 11'd39;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  function automatic logic [CNT_W-1:0] baud_div(input logic [2:0] sel);
    logic [CNT_W-1:0] d;
    case (sel)
      3'b000:  d = DIV_000;
      3'b001:  d = DIV_001;
      3'b010:  d = DIV_010;
      3'b011:  d = DIV_011;
      3'b100:  d = DIV_100;
      3'b101:  d = DIV_101;
      3'b110:  d = DIV_110;
      default: d = DIV_111;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line,
// plus an optional three-sample majority filter.
// Configuration macro: UART_RX_MAJORITY_EN (defined -> majority filter).
// Ports:
//   clock      in   system clock
//   reset      in   asynchronous active-high reset
//   rx_serial  in   raw serial line (idles high)
//   sync2      out  synchronized line, used for start/idle detection
//   sample     out  value the FSM samples bits with
module uart_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic rx_serial,
  output logic sync2,
  output logic sample
);

  logic sync1;

  // Flops reset to 1 so the idle-high line does not look like a start bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make sync1->sync2 a real two-stage
      // pipeline; blocking ones would collapse it into a single flop.
      sync1 <= rx_serial;
      sync2 <= sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Previous two values of sync2; together with sync2 itself they form the
  // three-sample window, so the sample point does not move.
  logic [1:0] hist;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) hist <= 2'b11;
    else       hist <= {hist[0], sync2};
  end

  assign sample = (sync2 & hist[0]) | (sync2 & hist[1]) | (hist[0] & hist[1]);
`else
  assign sample = sync2;
`endif

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver (1 start, 8 data LSB-first, 1 stop).
// Configuration macro: UART_RX_MAJORITY_EN (majority-vote bit sampling,
// implemented in uart_rx_sync).
// Ports:
//   clock             in   system clock, rising edge
//   reset             in   asynchronous active-high reset
//   baud_rate_select  in   divisor select, see uart_pkg::baud_div
//   Rx_Serial         in   asynchronous serial line, idles high
//   Rx_Byte           out  last correctly framed byte
//   Rx_Valid          out  one-cycle pulse, Rx_Byte is new
//   Rx_Frame_Err      out  one-cycle pulse, stop bit sampled low
//   Rx_Active         out  high while a frame is in progress (state != IDLE)
module uart_rx
  import uart_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] baud_rate_select,
  input  logic       Rx_Serial,
  output logic [7:0] Rx_Byte,
  output logic       Rx_Valid,
  output logic       Rx_Frame_Err,
  output logic       Rx_Active
);

  logic             sync2;
  logic             sample;
  rx_state_t        state;
  logic [CNT_W-1:0] clk_count;
  logic [2:0]       bit_index;
  logic [7:0]       shift_reg;
  logic [CNT_W-1:0] div_lat;
  logic [CNT_W-1:0] half;

  uart_rx_sync u_sync (
    .clock     (clock),
    .reset     (reset),
    .rx_serial (Rx_Serial),
    .sync2     (sync2),
    .sample    (sample)
  );

  assign half      = div_lat >> 1;
  assign Rx_Active = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      clk_count    <= '0;
      bit_index    <= '0;
      // NOTE: shift_reg and div_lat are reset too; they are small and a known
      // value keeps simulation free of X without affecting function.
      shift_reg    <= '0;
      div_lat      <= DIV_111;
      Rx_Byte      <= '0;
      Rx_Valid     <= 1'b0;
      Rx_Frame_Err <= 1'b0;
    end else begin
      // Strobes default low so each is high for exactly one cycle.
      Rx_Valid     <= 1'b0;
      Rx_Frame_Err <= 1'b0;

      case (state)
        IDLE: begin
          clk_count <= '0;
          bit_index <= '0;
          if (!sync2) begin
            // Divisor is frozen for the whole frame.
            div_lat <= baud_div(baud_rate_select);
            state   <= START_BIT;
          end
        end

        START_BIT: begin
          if (clk_count == half - 1'b1) begin
            clk_count <= '0;
            // Line back high at mid-start: a glitch, not a frame.
            state     <= sample ? IDLE : DATA_BITS;
          end else begin
            clk_count <= clk_count + 1'b1;
          end
        end

        DATA_BITS: begin
          if (clk_count == div_lat - 1'b1) begin
            clk_count            <= '0;
            shift_reg[bit_index] <= sample;
            if (bit_index == 3'd7) begin
              bit_index <= '0;
              state     <= STOP_BIT;
            end else begin
              bit_index <= bit_index + 1'b1;
            end
          end else begin
            clk_count <= clk_count + 1'b1;
          end
        end

        STOP_BIT: begin
          if (clk_count == div_lat - 1'b1) begin
            clk_count <= '0;
            if (sample) begin
              // Returning to IDLE mid-stop-bit lets a back-to-back start
              // bit be caught on its falling edge.
              Rx_Byte  <= shift_reg;
              Rx_Valid <= 1'b1;
              state    <= IDLE;
            end else begin
              Rx_Frame_Err <= 1'b1;
              state        <= WAIT_IDLE;
            end
          end else begin
            clk_count <= clk_count + 1'b1;
          end
        end

        WAIT_IDLE: begin
          // A held-low line (break) must not look like a new start bit.
          clk_count <= '0;
          bit_index <= '0;
          if (sync2) state <= IDLE;
        end

        default: begin
          clk_count <= '0;
          bit_index <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx.
// Line changes are driven on the falling clock edge; the posedge following a
// falling start-bit drive is E0. Outputs are observed on falling edges, where
// the free-running posedge counter "cyc" equals the index of the last E.
module tb_uart_rx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] baud_rate_select = 3'b111;
  logic       Rx_Serial = 1'b1;
  logic [7:0] Rx_Byte;
  logic       Rx_Valid;
  logic       Rx_Frame_Err;
  logic       Rx_Active;

  uart_rx dut (
    .clock            (clock),
    .reset            (reset),
    .baud_rate_select (baud_rate_select),
    .Rx_Serial        (Rx_Serial),
    .Rx_Byte          (Rx_Byte),
    .Rx_Valid         (Rx_Valid),
    .Rx_Frame_Err     (Rx_Frame_Err),
    .Rx_Active        (Rx_Active)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  // Monitor: log strobes and Rx_Active edges.
  int         valid_cyc[$];
  logic [7:0] valid_byte[$];
  int         err_cyc[$];
  int         both_cnt = 0;
  int         act_rise = -1;
  int         act_fall = -1;
  logic       act_prev = 1'b0;

  always @(negedge clock) begin
    if (Rx_Valid) begin
      valid_cyc.push_back(cyc);
      valid_byte.push_back(Rx_Byte);
    end
    if (Rx_Frame_Err) err_cyc.push_back(cyc);
    if (Rx_Valid && Rx_Frame_Err) both_cnt++;
    if (Rx_Active && !act_prev) act_rise = cyc;
    if (!Rx_Active && act_prev) act_fall = cyc;
    act_prev = Rx_Active;
  end

  task automatic clear_log();
    valid_cyc.delete();
    valid_byte.delete();
    err_cyc.delete();
  endtask

  int last_drive_cyc = 0;
  int frame_t0 = 0;

  // Set the line at a falling edge and hold it for n clock cycles.
  task automatic drive_bit(input logic v, input int n);
    @(negedge clock);
    Rx_Serial = v;
    last_drive_cyc = cyc;
    repeat (n - 1) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
    drive_bit(1'b0, div);
    frame_t0 = last_drive_cyc + 1;
    for (int i = 0; i < 8; i++) drive_bit(b[i], div);
    drive_bit(stop, div);
  endtask

  logic [7:0] glitch_exp;
  int         t_a;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, n_pass=%0d n_checks=%0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values.
    #2;
    check("reset_byte",   Rx_Byte,      8'h00);
    check("reset_valid",  Rx_Valid,     1'b0);
    check("reset_err",    Rx_Frame_Err, 1'b0);
    check("reset_active", Rx_Active,    1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    drive_bit(1'b1, 10);

    // Basic frame, div 39: valid after E372, active E2..E372.
    clear_log();
    baud_rate_select = 3'b111;
    send_frame(8'hA5, 1'b1, 39);
    drive_bit(1'b1, 20);
    check("basic_valid_cnt", valid_cyc.size(), 1);
    check("basic_valid_time", (valid_cyc.size() > 0) ? valid_cyc[0] : -1, frame_t0 + 372);
    check("basic_byte_strobe", (valid_byte.size() > 0) ? valid_byte[0] : 8'hXX, 8'hA5);
    check("basic_byte_hold", Rx_Byte, 8'hA5);
    check("basic_err_cnt", err_cyc.size(), 0);
    check("basic_active_rise", act_rise, frame_t0 + 2);
    check("basic_active_fall", act_fall, frame_t0 + 372);

    // Back-to-back frames, div 87 (half 43): valid at E828, 870 apart.
    clear_log();
    baud_rate_select = 3'b101;
    send_frame(8'h00, 1'b1, 87);
    t_a = frame_t0;
    send_frame(8'hFF, 1'b1, 87);
    drive_bit(1'b1, 20);
    check("b2b_valid_cnt", valid_cyc.size(), 2);
    check("b2b_first_time", (valid_cyc.size() > 0) ? valid_cyc[0] : -1, t_a + 828);
    check("b2b_spacing", (valid_cyc.size() > 1) ? valid_cyc[1] - valid_cyc[0] : -1, 870);
    check("b2b_byte0", (valid_byte.size() > 0) ? valid_byte[0] : 8'hXX, 8'h00);
    check("b2b_byte1", (valid_byte.size() > 1) ? valid_byte[1] : 8'hXX, 8'hFF);

    // False start: 10 low cycles, then high.
    clear_log();
    baud_rate_select = 3'b111;
    drive_bit(1'b0, 10);
    drive_bit(1'b1, 60);
    check("false_valid_cnt", valid_cyc.size(), 0);
    check("false_err_cnt", err_cyc.size(), 0);
    check("false_active", Rx_Active, 1'b0);
    check("false_byte", Rx_Byte, 8'hFF);

    // Framing error, line held low afterwards; then a good frame.
    clear_log();
    send_frame(8'h3C, 1'b0, 39);
    drive_bit(1'b0, 100);
    check("ferr_err_cnt", err_cyc.size(), 1);
    check("ferr_err_time", (err_cyc.size() > 0) ? err_cyc[0] : -1, frame_t0 + 372);
    check("ferr_valid_cnt", valid_cyc.size(), 0);
    check("ferr_byte_kept", Rx_Byte, 8'hFF);
    check("ferr_wait_idle", Rx_Active, 1'b1);
    drive_bit(1'b1, 20);
    check("ferr_idle_after", Rx_Active, 1'b0);
    send_frame(8'h81, 1'b1, 39);
    drive_bit(1'b1, 20);
    check("ferr_next_cnt", valid_cyc.size(), 1);
    check("ferr_next_byte", Rx_Byte, 8'h81);
    check("ferr_err_once", err_cyc.size(), 1);

    // Reset during data bit 4 of 0xC3.
    clear_log();
    drive_bit(1'b0, 39);
    for (int i = 0; i < 4; i++) drive_bit(i < 2, 39);
    drive_bit(1'b0, 15);
    reset = 1'b1;
    Rx_Serial = 1'b1;
    #1;
    check("rst_mid_byte",   Rx_Byte,      8'h00);
    check("rst_mid_valid",  Rx_Valid,     1'b0);
    check("rst_mid_err",    Rx_Frame_Err, 1'b0);
    check("rst_mid_active", Rx_Active,    1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    drive_bit(1'b1, 20);
    check("rst_mid_no_strobe", valid_cyc.size() + err_cyc.size(), 0);
    send_frame(8'h5A, 1'b1, 39);
    drive_bit(1'b1, 20);
    check("rst_next_cnt", valid_cyc.size(), 1);
    check("rst_next_byte", Rx_Byte, 8'h5A);

    // One-cycle glitch at the data-bit-2 sample point of 0x00.
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h04;
`endif
    clear_log();
    drive_bit(1'b0, 39);
    drive_bit(1'b0, 39);
    drive_bit(1'b0, 39);
    drive_bit(1'b0, 19);
    drive_bit(1'b1, 1);
    drive_bit(1'b0, 19);
    for (int i = 3; i < 8; i++) drive_bit(1'b0, 39);
    drive_bit(1'b1, 39);
    drive_bit(1'b1, 20);
    check("glitch_cnt", valid_cyc.size(), 1);
    check("glitch_byte", Rx_Byte, glitch_exp);

    check("never_both_strobes", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that recovers 8N1 bytes (1 start, 8 data LSB-first, 1 stop) from an asynchronous line driven by the design's UART transmitter or an external device. It uses the same eight-entry baud-select table as the transmit side, so both ends of a link share one `baud_rate_select` encoding. It emits each received byte with a one-cycle valid strobe and flags framing errors.

## Interface
Parameters:
- none; divisors come from the shared package.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `baud_rate_select`  in  3  divisor select: 000=1042, 001=695, 010=521, 011=261, 100=174, 101=87, 110=79, 111=39 clocks per bit.
- `Rx_Serial`  in  1  asynchronous serial line; idles high.
- `Rx_Byte`  out  8  last correctly framed byte; holds until the next good frame.
- `Rx_Valid`  out  1  one-cycle pulse; `Rx_Byte` is new.
- `Rx_Frame_Err`  out  1  one-cycle pulse; stop bit sampled low.
- `Rx_Active`  out  1  high from start detection until return to IDLE.

## Operation
- `Rx_Serial` passes through a 2-flop synchronizer (`sync1`, `sync2`). Both flops reset to 1.
- `div` is the table divisor. `half` = `div >> 1`. The divisor is latched on start detection; changes to `baud_rate_select` mid-frame have no effect.
- `clk_count` is 11 bits and `bit_index` is 3 bits. Both are zeroed on every state entry.
- The sample value is `sync2`, or the majority value when majority voting is configured (see Configuration).
- States:
  - IDLE: `Rx_Active`=0. If `sync2`==0, go to START_BIT.
  - START_BIT: increment `clk_count` until it equals `half-1`. At that point:
    - sample==0: go to DATA_BITS.
    - sample==1: false start; return to IDLE with no flags.
  - DATA_BITS: increment `clk_count` until it equals `div-1`. At that point:
    - shift the sample into `shift_reg[bit_index]` and zero `clk_count`.
    - if `bit_index`==7, go to STOP_BIT; otherwise increment `bit_index`.
  - STOP_BIT: increment `clk_count` until it equals `div-1`. At that point:
    - sample==1: load `Rx_Byte` from `shift_reg`, pulse `Rx_Valid`, go to IDLE.
    - sample==0: pulse `Rx_Frame_Err`, leave `Rx_Byte` unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `sync2`==1, then go to IDLE. This prevents a break condition from re-triggering start detection.
- Any undefined state encoding returns to IDLE.
- `Rx_Valid` and `Rx_Frame_Err` are never high together.
- `Rx_Active` = state != IDLE.

## Timing
- Reset values:
  - `Rx_Byte`=0x00, `Rx_Valid`=0, `Rx_Frame_Err`=0, `Rx_Active`=0.
  - state=IDLE, counters=0, sync flops=1.
- Call the first clock edge at which `sync1` captures a low E0. Then:
  - START_BIT is entered at E2.
  - Data bit k is sampled at E(2+half+(k+1)·div).
  - The stop bit is sampled at E(2+half+9·div).
  - `Rx_Valid` (or `Rx_Frame_Err`) is high for exactly the cycle after that edge.
- Example: `div`=39 gives `Rx_Valid` high after E372.
- Back-to-back frames are supported. A start bit immediately following a stop bit is detected, because IDLE is re-entered half a bit before the stop bit ends.
- Reset asserted mid-frame aborts the frame immediately, with no strobe and `Rx_Byte` cleared.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - A 3-bit history register holds `sync2` over the last three cycles.
  - sample = majority of the three values.
  - A single-cycle glitch at the sampling point is rejected.
  - Latency is unchanged.
- Not defined: sample = `sync2`; the history register is absent.

## Structure
- Shared package `uart_pkg`:
  - baud-select-to-divisor function and the eight divisor constants (shared with the transmitter);
  - state encoding constants IDLE, START_BIT, DATA_BITS, STOP_BIT, WAIT_IDLE (3 bits).
- One sub-module, `uart_rx_sync`: the 2-flop synchronizer plus the optional majority filter. It outputs `sync2` and the sample value.
- The FSM, counters and shift register live in `uart_rx`.

## Test plan
- Basic frame: select 111, send 0xA5 -> `Rx_Valid` for 1 cycle after E372, `Rx_Byte`=0xA5, `Rx_Frame_Err`=0, `Rx_Active` high E2..E372.
- Back-to-back frames: select 101, send 0x00 then 0xFF with no idle gap -> two `Rx_Valid` pulses 870 cycles apart, bytes 0x00 then 0xFF.
- False start: select 111, drive low for 10 cycles then high -> no strobe, return to IDLE, `Rx_Byte` unchanged.
- Framing error: select 111, send 0x3C with stop bit low, hold low 100 cycles, then high -> one `Rx_Frame_Err` pulse, `Rx_Byte` keeps its previous value, stays in WAIT_IDLE until the line goes high, then the next frame 0x81 is received correctly.
- Reset mid-frame: assert `reset` during data bit 4 -> all outputs at reset values, no strobe; the next frame 0x5A is received correctly.
- Glitch at sampling point: with `UART_RX_MAJORITY_EN`, flip the line for 1 cycle at the data-bit-2 sample point of 0x00 -> `Rx_Byte`=0x00. Without the macro -> `Rx_Byte`=0x04.
